pipeline_flush_ctrl: RTL
========================

# pipeline_flush_ctrl

Parametrised, stateful stall/flush controller for the RV32IM in-order pipeline, placed between the hazard detection unit, branch unit, mul/div unit and trap logic on one side and the PC and pipeline registers on the other. Per cycle it produces a per-register hold vector and a per-register flush (bubble) vector. It generalises the fixed load-use/branch flush decode to N pipeline registers, a configurable branch-resolve stage, multi-cycle load-use bubbles, multi-cycle mul/div stalls and trap flushes.

## Interface
- NUM_PREGS, 4: number of pipeline registers; index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB.
- BJ_STAGE, 2: index of the first register not flushed on a taken branch/jump (branch resolves in EX). Legal range 1..NUM_PREGS-1.
- LU_BUBBLES, 1: load-use stall length in cycles, ≥1.
- MD_LATENCY, 4: mul/div occupancy of EX in cycles, ≥2.
- CLK  in  1  clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SIG_HAZARDS_D  in  1  load-use hazard detected in decode, level.
- SIG_BJ  in  1  taken branch/jump resolved at BJ_STAGE, level.
- SIG_MD_START  in  1  mul/div instruction in EX this cycle, first cycle only.
- SIG_TRAP  in  1  exception/trap taken, level.
- PC_STALL  out  1  hold PC.
- P_STALL  out  NUM_PREGS  hold pipeline register i.
- P_FLUSH  out  NUM_PREGS  load bubble (NOP) into pipeline register i.
- BUSY  out  1  state ≠ IDLE.
- PERF_STALLS  out  32  stall-cycle counter (see Configuration).
- PERF_FLUSHES  out  32  flush-event counter (see Configuration).

## Operation
- FSM states:
  - IDLE
  - LU_STALL: load-use bubbles remaining.
  - MD_STALL: mul/div busy.
- Down-counter CNT. Width is $clog2(max(LU_BUBBLES, MD_LATENCY))+1.
- Outputs are Mealy (state + current inputs). State and CNT are registered.
- Priority per cycle: TRAP > BJ > mul/div > load-use.
- TRAP, in any state:
  - P_FLUSH all ones, P_STALL = 0, PC_STALL = 0.
  - Next state IDLE, CNT = 0.
- BJ, in IDLE or LU_STALL:
  - P_FLUSH[i] = 1 for i < BJ_STAGE; all others 0.
  - P_STALL = 0, PC_STALL = 0.
  - Next state IDLE; any pending load-use bubbles are cancelled.
- BJ in MD_STALL is ignored; EX holds the mul/div instruction.
- MD_START in IDLE, no TRAP/BJ:
  - PC_STALL = 1, P_STALL[1:0] = 2'b11, P_FLUSH[2] = 1.
  - CNT loaded with MD_LATENCY-2.
  - Next state MD_STALL if MD_LATENCY > 2, else stay IDLE.
- MD_STALL: same outputs. CNT decrements each cycle; at CNT == 1 the next state is IDLE.
- Total mul/div stall is exactly MD_LATENCY-1 cycles.
- SIG_HAZARDS_D in IDLE, no higher-priority event:
  - PC_STALL = 1, P_STALL[0] = 1, P_FLUSH[1] = 1.
  - If LU_BUBBLES > 1: CNT = LU_BUBBLES-1, next state LU_STALL.
- LU_STALL: same outputs until CNT reaches 0, then IDLE. SIG_HAZARDS_D is not re-sampled while in LU_STALL.
- SIG_HAZARDS_D and SIG_MD_START in MD_STALL are ignored; decode re-evaluates after exit.
- No stall and no flush on a register in the same cycle: flush wins and the stall bit is cleared.

## Timing
- Reset values: state IDLE, CNT 0, all outputs 0, perf counters 0.
- Reset asserted mid-stall aborts immediately (asynchronous); outputs drop to 0 with no settling cycle.
- Input-to-output latency is 0 cycles (combinational). State change takes effect the next edge.
- Stall durations:
  - Load-use: exactly LU_BUBBLES cycles.
  - Mul/div: exactly MD_LATENCY-1 cycles.
- Simultaneous TRAP + BJ + MD_START + HAZARD resolves to TRAP behaviour only.

## Configuration
- PFLUSH_PERF_EN defined:
  - PERF_STALLS increments on every cycle with PC_STALL = 1.
  - PERF_FLUSHES increments on every cycle with any P_FLUSH bit set.
  - Both are 32-bit, wrap 0xFFFFFFFF → 0, and are cleared by reset.
- PFLUSH_PERF_EN undefined: counters are not synthesised; PERF_STALLS and PERF_FLUSHES are tied to 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - State enum: IDLE, LU_STALL, MD_STALL.
  - Register index constants: PREG_IFID = 0, PREG_IDEX = 1, PREG_EXMEM = 2, PREG_MEMWB = 3.
- One sub-module, stall_down_counter: loadable down-counter with a zero/one flag. The FSM and output decode stay in the top module.

## Test plan
- Reset with SIG_HAZARDS_D = 1 held → all outputs 0. Release → PC_STALL = 1, P_STALL = 4'b0001, P_FLUSH = 4'b0010 for exactly LU_BUBBLES cycles.
- LU_BUBBLES = 3; BJ in the 2nd bubble → P_FLUSH = 4'b0011 that cycle, then IDLE, with no further stall.
- MD_LATENCY = 4: MD_START pulse → PC_STALL high for 3 cycles, P_FLUSH = 4'b0100, BUSY high for 2 cycles.
- MD_STALL with SIG_HAZARDS_D and SIG_BJ asserted → both ignored, stall length unchanged; TRAP then → P_FLUSH = 4'b1111 and IDLE next cycle.
- All four inputs high in one cycle → P_FLUSH = 4'b1111, P_STALL = 0, PC_STALL = 0.
- PFLUSH_PERF_EN on, counters preloaded near 0xFFFFFFFF via force → PERF_STALLS wraps to 0. Macro off → both counter outputs stay 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared FSM state type, pipeline register indices and helpers for pipeline_flush_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MD_STALL = 2'd2
    } state_e;

    localparam int unsigned PREG_IFID  = 0;
    localparam int unsigned PREG_IDEX  = 1;
    localparam int unsigned PREG_EXMEM = 2;
    localparam int unsigned PREG_MEMWB = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stall_down_counter.sv
// Loadable down-counter that saturates at zero and flags the zero and one counts.
module stall_down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             is_zero,
    output logic             is_one
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign is_zero = (cnt_q == '0);
    assign is_one  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// Stall/flush controller for the in-order pipeline: trap > branch > mul/div > load-use.
// Optional perf counters are built when PFLUSH_PERF_EN is defined.
module pipeline_flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PREGS  = 4,
    parameter int unsigned BJ_STAGE   = 2,
    parameter int unsigned LU_BUBBLES = 1,
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 SIG_HAZARDS_D,
    input  logic                 SIG_BJ,
    input  logic                 SIG_MD_START,
    input  logic                 SIG_TRAP,
    output logic                 PC_STALL,
    output logic [NUM_PREGS-1:0] P_STALL,
    output logic [NUM_PREGS-1:0] P_FLUSH,
    output logic                 BUSY,
    output logic [31:0]          PERF_STALLS,
    output logic [31:0]          PERF_FLUSHES
);

    localparam int unsigned CNT_MAX = max_u(LU_BUBBLES, MD_LATENCY);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LU_BUBBLES - 1);

    localparam logic [NUM_PREGS-1:0] BJ_MASK    = NUM_PREGS'((1 << BJ_STAGE) - 1);
    localparam logic [NUM_PREGS-1:0] LU_STALL_V = NUM_PREGS'(1 << PREG_IFID);
    localparam logic [NUM_PREGS-1:0] LU_FLUSH_V = NUM_PREGS'(1 << PREG_IDEX);
    localparam logic [NUM_PREGS-1:0] MD_STALL_V = NUM_PREGS'((1 << PREG_IFID) | (1 << PREG_IDEX));
    localparam logic [NUM_PREGS-1:0] MD_FLUSH_V = NUM_PREGS'(1 << PREG_EXMEM);

    state_e               state_q;
    state_e               state_d;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 cnt_zero;
    logic                 cnt_one;
    logic                 pc_stall_c;
    logic [NUM_PREGS-1:0] p_stall_c;
    logic [NUM_PREGS-1:0] p_flush_c;

    stall_down_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .is_zero  (cnt_zero),
        .is_one   (cnt_one)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter control and Mealy stall/flush decode.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        pc_stall_c   = 1'b0;
        p_stall_c    = '0;
        p_flush_c    = '0;

        if (SIG_TRAP) begin
            p_flush_c = '1;
            state_d   = IDLE;
            cnt_load  = 1'b1;
        end else if (SIG_BJ && (state_q != MD_STALL)) begin
            p_flush_c = BJ_MASK;
            state_d   = IDLE;
            cnt_load  = 1'b1;
        end else begin
            case (state_q)
                MD_STALL: begin
                    pc_stall_c = 1'b1;
                    p_stall_c  = MD_STALL_V;
                    p_flush_c  = MD_FLUSH_V;
                    cnt_dec    = 1'b1;
                    if (cnt_one || cnt_zero) begin
                        state_d = IDLE;
                    end
                end
                LU_STALL: begin
                    pc_stall_c = 1'b1;
                    p_stall_c  = LU_STALL_V;
                    p_flush_c  = LU_FLUSH_V;
                    cnt_dec    = 1'b1;
                    if (cnt_one || cnt_zero) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    if (SIG_MD_START) begin
                        pc_stall_c   = 1'b1;
                        p_stall_c    = MD_STALL_V;
                        p_flush_c    = MD_FLUSH_V;
                        cnt_load     = 1'b1;
                        cnt_load_val = MD_LOAD;
                        state_d      = (MD_LATENCY > 2) ? MD_STALL : IDLE;
                    end else if (SIG_HAZARDS_D) begin
                        pc_stall_c = 1'b1;
                        p_stall_c  = LU_STALL_V;
                        p_flush_c  = LU_FLUSH_V;
                        if (LU_BUBBLES > 1) begin
                            cnt_load     = 1'b1;
                            cnt_load_val = LU_LOAD;
                            state_d      = LU_STALL;
                        end
                    end
                end
            endcase
        end
    end

    // Reset forces outputs low immediately; a flushed register is never also held.
    assign PC_STALL = RESET_N & pc_stall_c;
    assign P_STALL  = {NUM_PREGS{RESET_N}} & p_stall_c & ~p_flush_c;
    assign P_FLUSH  = {NUM_PREGS{RESET_N}} & p_flush_c;
    assign BUSY     = (state_q != IDLE);

`ifdef PFLUSH_PERF_EN
    logic [31:0] perf_stalls_q;
    logic [31:0] perf_flushes_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            perf_stalls_q  <= 32'd0;
            perf_flushes_q <= 32'd0;
        end else begin
            if (PC_STALL) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
            if (|P_FLUSH) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
        end
    end

    assign PERF_STALLS  = perf_stalls_q;
    assign PERF_FLUSHES = perf_flushes_q;
`else
    assign PERF_STALLS  = 32'd0;
    assign PERF_FLUSHES = 32'd0;
`endif

endmodule
